// File: rtl/core_pkg.sv
// Shared core definitions: default widths and register-file types.
// Imported by the register file, its read ports, its interface and the bench.
package core_pkg;

  localparam int XLEN_DEF       = 32;
  localparam int NUM_REGS_RV32E = 16;
  localparam int SEL_W_DEF      = 5;

  typedef logic [SEL_W_DEF-1:0] reg_sel_t;
  typedef logic [XLEN_DEF-1:0]  xword_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback side bus of the register file with its load scoreboard.
// master = decode/writeback driving the file, slave = the register file.
interface regfile_scoreboard_if
  import core_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int SEL_W = SEL_W_DEF
);

  logic             wr_en;
  logic [SEL_W-1:0] wr_sel;
  logic [XLEN-1:0]  wr_value;
  logic             wr_load;
  logic [SEL_W-1:0] rd_sel1;
  logic [XLEN-1:0]  rd_value1;
  logic [SEL_W-1:0] rd_sel2;
  logic [XLEN-1:0]  rd_value2;
  logic             pend_set;
  logic [SEL_W-1:0] pend_sel;
  logic             hazard1;
  logic             hazard2;
  logic             pending_any;

  modport master (
    output wr_en, wr_sel, wr_value, wr_load,
    output rd_sel1, rd_sel2, pend_set, pend_sel,
    input  rd_value1, rd_value2, hazard1, hazard2, pending_any
  );

  modport slave (
    input  wr_en, wr_sel, wr_value, wr_load,
    input  rd_sel1, rd_sel2, pend_set, pend_sel,
    output rd_value1, rd_value2, hazard1, hazard2, pending_any
  );

endinterface

// File: rtl/regfile_scoreboard_read_port.sv
// One combinational read port: register mux plus pending-bit hazard lookup.
// Optional same-cycle write-through and retire bypass under REGFILE_BYPASS_EN.
module regfile_read_port
  import core_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_RV32E,
  parameter int XLEN     = XLEN_DEF,
  parameter int SEL_W    = SEL_W_DEF
) (
  input  logic [SEL_W-1:0]         rd_sel_i,
  input  logic [NUM_REGS*XLEN-1:0] regs_flat_i,
  input  logic [NUM_REGS-1:0]      pend_i,
  input  logic                     wr_en_i,
  input  logic [SEL_W-1:0]         wr_sel_i,
  input  logic [XLEN-1:0]          wr_value_i,
  input  logic                     wr_load_i,
  output logic [XLEN-1:0]          rd_value_o,
  output logic                     hazard_o
);

  logic [XLEN-1:0] stored_value;
  logic            stored_hazard;
  logic            unused_slot0;

  // Slot 0 is x0; selects 0 and out-of-range fall through to the zero default.
  assign unused_slot0 = ^{regs_flat_i[XLEN-1:0], pend_i[0]};

  always_comb begin
    stored_value  = '0;
    stored_hazard = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (32'(rd_sel_i) == 32'(i)) begin
        stored_value  = regs_flat_i[i*XLEN +: XLEN];
        stored_hazard = pend_i[i];
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic bypass_hit;

  assign bypass_hit = wr_en_i && (wr_sel_i != '0) && (32'(wr_sel_i) < NUM_REGS)
                      && (wr_sel_i == rd_sel_i);
  assign rd_value_o = bypass_hit ? wr_value_i : stored_value;
  assign hazard_o   = stored_hazard && !(bypass_hit && wr_load_i);
`else
  logic unused_bypass;

  assign unused_bypass = ^{wr_en_i, wr_sel_i, wr_value_i, wr_load_i};
  assign rd_value_o    = stored_value;
  assign hazard_o      = stored_hazard;
`endif

endmodule

// File: rtl/regfile_scoreboard.sv
// RV32E register file (x0 hardwired to zero) with per-register load-pending scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes and retires to the read ports.
module regfile_scoreboard
  import core_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_RV32E,
  parameter int XLEN     = XLEN_DEF,
  parameter int SEL_W    = SEL_W_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_scoreboard_if.slave bus
);

  logic [XLEN-1:0]          regs_q [1:NUM_REGS-1];
  logic [XLEN-1:0]          regs_d [1:NUM_REGS-1];
  logic [NUM_REGS-1:1]      pend_q;
  logic [NUM_REGS-1:1]      pend_d;
  logic                     wr_hit;
  logic [NUM_REGS*XLEN-1:0] regs_flat;
  logic [NUM_REGS-1:0]      pend_vec;

  assign wr_hit = bus.wr_en && (bus.wr_sel != '0) && (32'(bus.wr_sel) < NUM_REGS);

  // A new load issued to the register retiring this cycle keeps it pending.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (wr_hit && 32'(bus.wr_sel) == 32'(i)) begin
        regs_d[i] = bus.wr_value;
      end
      if (bus.pend_set && 32'(bus.pend_sel) == 32'(i)) begin
        pend_d[i] = 1'b1;
      end else if (wr_hit && bus.wr_load && 32'(bus.wr_sel) == 32'(i)) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      regs_flat[i*XLEN +: XLEN] = regs_q[i];
    end
  end

  assign pend_vec        = {pend_q, 1'b0};
  assign bus.pending_any = |pend_q;

  regfile_read_port #(
    .NUM_REGS (NUM_REGS),
    .XLEN     (XLEN),
    .SEL_W    (SEL_W)
  ) u_rd1 (
    .rd_sel_i    (bus.rd_sel1),
    .regs_flat_i (regs_flat),
    .pend_i      (pend_vec),
    .wr_en_i     (bus.wr_en),
    .wr_sel_i    (bus.wr_sel),
    .wr_value_i  (bus.wr_value),
    .wr_load_i   (bus.wr_load),
    .rd_value_o  (bus.rd_value1),
    .hazard_o    (bus.hazard1)
  );

  regfile_read_port #(
    .NUM_REGS (NUM_REGS),
    .XLEN     (XLEN),
    .SEL_W    (SEL_W)
  ) u_rd2 (
    .rd_sel_i    (bus.rd_sel2),
    .regs_flat_i (regs_flat),
    .pend_i      (pend_vec),
    .wr_en_i     (bus.wr_en),
    .wr_sel_i    (bus.wr_sel),
    .wr_value_i  (bus.wr_value),
    .wr_load_i   (bus.wr_load),
    .rd_value_o  (bus.rd_value2),
    .hazard_o    (bus.hazard2)
  );

endmodule
